// File: rtl/ifetch_unit_pkg.sv
// Shared core constants for the fetch unit and the imem/dmem/regfile users.
package ifetch_unit_pkg;
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction addresses are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/ifetch_unit.sv
// Single-stage instruction fetch: pc register, registered output slot with
// valid/ready handshake, redirect handling and an accepted-instruction counter.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] fetch_count
);
    logic [XLEN-1:0] pc_q, pc_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;
    logic            load;
    logic            xfer;

    assign load = !out_valid_q || out_ready;
    assign xfer = out_valid_q && out_ready;

    always_comb begin
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        // A transfer still counts when a redirect squashes the next fetch.
        fetch_count_d = fetch_count_q + {31'd0, xfer};
        if (redirect_valid) begin
            pc_d        = word_align(redirect_pc);
            out_valid_d = 1'b0;
        end else if (load) begin
            out_instr_d = idata;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= word_align(RESET_PC);
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign iaddr       = pc_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the fetch stream.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [256];
    assign idata = mem[iaddr[9:2]];

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: next address to fetch, and what sits in the output slot.
    logic [31:0] m_next;
    logic        m_full;
    logic [31:0] m_instr, m_pc;
    logic [31:0] m_count;
    bit          m_init = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_next = 32'h0; m_full = 0; m_instr = 0; m_pc = 0; m_count = 0;
            m_init = 1;
        end else if (m_init) begin
            if (m_full && out_ready) m_count = m_count + 1;
            if (redirect_valid) begin
                m_next = redirect_pc & 32'hFFFF_FFFC;
                m_full = 0;
            end else if (!m_full || out_ready) begin
                m_instr = mem[m_next[9:2]];
                m_pc    = m_next;
                m_full  = 1;
                m_next  = m_next + 4;
            end
        end
        #1;
        if (m_init) begin
            chk("iaddr", iaddr, m_next);
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
            chk("fetch_count", fetch_count, m_count);
            if (m_full) begin
                chk("out_pc", out_pc, m_pc);
                chk("out_instr", out_instr, m_instr);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0013;

        // Reset held two cycles.
        reset = 1; out_ready = 0;
        cyc(); cyc();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);

        // First instruction one cycle after release, regardless of ready.
        reset = 0;
        cyc();
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        chk("first_pc", out_pc, 32'h0);
        chk("first_instr", out_instr, 32'h0000_0013);
        chk("first_count", fetch_count, 32'd0);

        // Stream to out_pc=8.
        out_ready = 1;
        cyc(); chk("stream_pc4", out_pc, 32'h4);
        cyc(); chk("stream_pc8", out_pc, 32'h8);

        // Stall three cycles at out_pc=8.
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", out_pc, 32'h8);
            chk("stall_instr", out_instr, mem[2]);
            chk("stall_iaddr", iaddr, 32'hC);
            chk("stall_count", fetch_count, 32'd2);
        end
        out_ready = 1;
        cyc(); chk("release_pc", out_pc, 32'hC);
        cyc(); chk("stream_count", fetch_count, 32'd4);
        chk("stream_pc10", out_pc, 32'h10);

        // Redirect with misaligned target while a transfer happens.
        redirect_valid = 1; redirect_pc = 32'h0000_0102;
        cyc();
        chk("redir_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_iaddr", iaddr, 32'h100);
        chk("redir_count", fetch_count, 32'd5);
        redirect_valid = 0;
        cyc();
        chk("redir_pc", out_pc, 32'h100);
        chk("redir_instr", out_instr, mem[8'h40]);
        chk("redir_count2", fetch_count, 32'd5);

        // Back-to-back redirects: only the last target survives.
        redirect_valid = 1; redirect_pc = 32'h200;
        cyc();
        redirect_pc = 32'h300;
        cyc();
        chk("b2b_valid", {31'd0, out_valid}, 32'd0);
        chk("b2b_iaddr", iaddr, 32'h300);
        redirect_valid = 0;
        cyc();
        chk("b2b_pc", out_pc, 32'h300);

        // PC wrap at the top of the address space.
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 0;
        cyc(); chk("wrap_pc_hi", out_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", out_instr, mem[255]);
        cyc(); chk("wrap_pc_0", out_pc, 32'h0);
        chk("wrap_instr0", out_instr, 32'h0000_0013);

        // Reset while stalled with a valid instruction.
        out_ready = 0;
        cyc();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        reset = 1;
        cyc();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_iaddr", iaddr, 32'h0);
        chk("mid_rst_count", fetch_count, 32'd0);
        reset = 0;
        cyc();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = ($urandom_range(0, 15) == 0) ? $urandom : {22'd0, 10'($urandom)};
            reset          = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 0; redirect_valid = 0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
